// File: rtl/sym_frame_aligner.sv
// Re-frames the raw I/Q stream onto estimator symbol boundaries (theta) and tags
// each emitted sample with the running CFO-correction phase for the derotator.
module sym_frame_aligner #(
  parameter int SAMP_W = 16,
  parameter int N      = 256,
  parameter int DEPTH  = 512,
  parameter int PH_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [SAMP_W-1:0] in_i,
  input  logic [SAMP_W-1:0] in_q,
  input  logic              est_valid,
  input  logic [7:0]        theta_in,
  input  logic [21:0]       eps_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SAMP_W-1:0] out_i,
  output logic [SAMP_W-1:0] out_q,
  output logic [PH_W-1:0]   out_ph,
  output logic              out_first,
  output logic              out_last,
  output logic              err_drop,
  output logic              err_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int RW = $clog2(N) + 1;
  // eps is Q1.20 turns per block; per-sample step in PH_W-bit turns is eps/N
  localparam int EPS_SH = 20 + $clog2(N) - PH_W;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state, state_n;
  logic [2*SAMP_W-1:0]   mem [DEPTH];
  logic [2*SAMP_W-1:0]   rd_word;
  logic [AW-1:0]         wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n, base;
  logic [FW-1:0]         fill, fill_n;
  logic [RW-1:0]         remaining, remaining_n, wr_seen, seen_n;
  logic [PH_W-1:0]       phase, phase_n, inc, inc_n, eps_step;
  logic                  err_drop_n, err_ovf_n;
  logic                  active, fire, last_fire, est_ok;

  // Read is combinational from the array, so a same-cycle write returns old data.
  always_ff @(posedge clk)
    if (in_valid) mem[wr_ptr] <= {in_i, in_q};

  assign rd_word   = mem[rd_ptr];
  assign active    = state == ACTIVE;
  assign out_valid = active && fill != '0;
  assign fire      = out_valid && out_ready;
  assign last_fire = fire && remaining == RW'(1);
  assign out_i     = active ? rd_word[2*SAMP_W-1:SAMP_W] : '0;
  assign out_q     = active ? rd_word[SAMP_W-1:0] : '0;
  assign out_ph    = active ? phase : '0;
  assign out_first = active && remaining == RW'(N);
  assign out_last  = active && remaining == RW'(1);

  always_comb begin
    state_n     = state;
    rd_ptr_n    = rd_ptr;
    fill_n      = fill;
    remaining_n = remaining;
    phase_n     = phase;
    inc_n       = inc;
    err_drop_n  = err_drop;
    err_ovf_n   = err_ovf;
    wr_ptr_n    = wr_ptr + AW'(in_valid);
    seen_n      = (wr_seen == RW'(N)) ? wr_seen : wr_seen + RW'(in_valid);
    est_ok      = seen_n == RW'(N);
    base        = wr_ptr_n - AW'(N);
    eps_step    = PH_W'($signed(eps_in) >>> EPS_SH);

    if (active) begin
      if (fire) begin
        rd_ptr_n    = rd_ptr + AW'(1);
        remaining_n = remaining - RW'(1);
        phase_n     = phase + inc;
      end
      if (fill == FW'(DEPTH) && in_valid && !fire) err_ovf_n = 1'b1;
      else fill_n = fill + FW'(in_valid) - FW'(fire);
      if (last_fire) state_n = IDLE;
    end

    // A pulse on the final-fire cycle chains straight into the next frame.
    if (est_valid) begin
      if ((!active || last_fire) && est_ok) begin
        rd_ptr_n    = base + AW'(theta_in);
        fill_n      = FW'(N) - FW'(theta_in);
        remaining_n = RW'(N);
        phase_n     = '0;
        inc_n       = -eps_step;
        state_n     = ACTIVE;
      end else begin
        err_drop_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      remaining <= '0;
      phase     <= '0;
      inc       <= '0;
      wr_seen   <= '0;
      err_drop  <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      fill      <= fill_n;
      remaining <= remaining_n;
      phase     <= phase_n;
      inc       <= inc_n;
      wr_seen   <= seen_n;
      err_drop  <= err_drop_n;
      err_ovf   <= err_ovf_n;
    end
  end
endmodule

// File: doc/sym_frame_aligner.md
Name: sym_frame_aligner

Overview:
- Consumer end of the timing/CFO estimator interface: takes the estimator's per-block symbol-start index (theta) and fractional CFO (eps, Q1.20).
- Re-frames the raw I/Q sample stream so that each emitted 256-sample symbol starts at stream offset theta within the estimated block.
- Tags every output sample with a CFO-correction phase word for the downstream derotator.
- Sits between the input sample FIFO and the NCO/CORDIC derotation stage.

Parameters:
- SAMP_W, 16, width of each of I and Q (signed).
- N, 256, symbol/block length (fixed; theta is 8 bits).
- DEPTH, 512, circular buffer depth in samples (2*N).
- PH_W, 16, phase word width, unsigned turns (2^16 = one turn).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample strobe; no backpressure, always written
- in_i  in  SAMP_W  input I
- in_q  in  SAMP_W  input Q
- est_valid  in  1  one-cycle pulse: theta_in/eps_in final for the block whose last (256th) sample is written this same cycle
- theta_in  in  8  symbol start offset within the block
- eps_in  in  22  CFO estimate, Q1.20 signed (eps_t)
- out_valid  out  1  output sample available
- out_ready  in  1  downstream accept
- out_i  out  SAMP_W  aligned I
- out_q  out  SAMP_W  aligned Q
- out_ph  out  PH_W  correction phase for this sample
- out_first  out  1  first sample of a frame (qualified by out_valid)
- out_last  out  1  256th sample of a frame (qualified by out_valid)
- err_drop  out  1  sticky: an est_valid was ignored
- err_ovf  out  1  sticky: buffer overrun during a frame

Behaviour:

Reset and write side
- Reset clears wr_ptr, rd_ptr, fill, remaining, phase, inc, wr_seen, err_drop and err_ovf, and sets state to IDLE.
- All outputs are 0 from reset. Reset mid-frame aborts the frame; no further samples are emitted.
- Write side: every in_valid cycle writes {in_i,in_q} to buf[wr_ptr]; wr_ptr is 9-bit and wraps 511 -> 0.
- wr_seen is a saturating counter of samples written since reset, 0..256.

IDLE state
- On est_valid: wr_ptr_n is wr_ptr after this cycle's write.
- If wr_seen (including this cycle's write) is below 256: the pulse is ignored, err_drop is set, and state stays IDLE.
- Otherwise:
  - base = wr_ptr_n - 256 (mod 512)
  - rd_ptr <= base + theta_in (mod 512)
  - fill <= 256 - theta_in (range 1..256)
  - remaining <= 256
  - phase <= 0
  - inc <= -(sign_extend_16(eps_in >>> 12)), arithmetic shift, mod 2^16
  - state -> ACTIVE
- inc is the per-sample rotation of -eps/N turns. Example: eps 0.5 (raw 0x80000) gives inc 0xFF80.

ACTIVE state
- out_valid = (fill != 0). It is combinational from registered state; no dependency on out_ready.
- out_i and out_q = buf[rd_ptr] (combinational read).
- out_ph = phase; out_first = (remaining == 256); out_last = (remaining == 1).
- fire = out_valid & out_ready. On fire: rd_ptr++, remaining--, phase += inc (mod 2^16).
- fill (10-bit) next = fill + in_valid - fire.
- If fill == 512 and in_valid & !fire: err_ovf is set and fill holds at 512. The write still occurs, overwriting unread data.
- Fire with remaining == 1 -> IDLE. In IDLE, out_valid = 0 and fill is not tracked.
- Latency: est_valid at cycle t gives the first out_valid at t+1.
- Data for stream positions theta..255 is available immediately. Positions 256..theta+255 are emitted only as they are written, so out_valid drops when input starves.

Simultaneous events
- est_valid in ACTIVE is ignored and sets err_drop. The exception is the cycle of the final fire: that pulse is accepted as in IDLE, and the next frame's first sample is presented in the following cycle.
- A write and a read of the same address in one cycle: the read returns the old contents.
- in_valid together with fire leaves fill unchanged.

Clearing
- err_drop and err_ovf clear only on rst.

Test Plan:
1. Reset check: hold rst 3 cycles mid-stream -> all outputs 0 and state IDLE. Then est_valid at the 100th post-reset sample -> err_drop = 1, out_valid stays 0.
2. Zero offset: continuous samples with I = index, Q = -index; est_valid with the 256th sample, theta 0, eps 0, out_ready = 1 -> out_i = 0..255 on 256 consecutive cycles starting next cycle, out_ph = 0 throughout, out_first on I = 0, out_last on I = 255.
3. Offset plus CFO: theta 100, eps 0.5 (0x080000), continuous input -> out_i sequence 100..355, out_ph 0x0000, 0xFF80, 0xFF00, ..., and out_ph = 0x8080 on the 256th sample (out_last, I = 355).
4. Starvation and backpressure: same as scenario 3, with input paused for 20 cycles after sample 300 and out_ready toggling 1,0,0,1 -> out_valid falls after I = 300, resumes when input resumes, and no sample is lost, duplicated or reordered.
5. Boundary est: est_valid during mid-frame -> err_drop = 1, current frame unaffected. est_valid in the cycle of the final fire -> new frame out_first appears the next cycle with the new theta.
6. Overrun: out_ready = 0 for 600 cycles of continuous input during ACTIVE -> err_ovf = 1 after fill reaches 512. Then assert rst mid-frame -> out_valid = 0 and err_ovf = 0 on the following cycle.
